// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port RAM with a 1-cycle registered read.
// Define RAM_PORT_ARBITER_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin with lock.
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              NCLR,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              lock0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  // Handshake: a requester raises reqN with stable we/addr/wdata and holds it until
  // gntN pulses (the cycle its access reaches the RAM); a read answers with a
  // one-cycle rvalidN two cycles later, with rdata valid only in that cycle.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              take;
  logic              win_d;
  logic              win_q;
  logic              we_q;
  logic              last_grant_q;
  logic              lock_valid_q;
  logic              lock_id_q;
  logic              issue_lock;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid0_q, rvalid1_q;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    win_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          take    = 1'b1;
          state_d = ST_ISSUE;
          if (req0 && !req1) begin
            win_d = 1'b0;
          end else if (!req0 && req1) begin
            win_d = 1'b1;
          end else begin
`ifdef RAM_PORT_ARBITER_FIXED_PRIO_EN
            win_d = 1'b0;
`else
            win_d = lock_valid_q ? lock_id_q : ~last_grant_q;
`endif
          end
        end
      end
      ST_ISSUE: state_d = we_q ? ST_IDLE : ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef RAM_PORT_ARBITER_FIXED_PRIO_EN
  assign issue_lock = ~win_q & lock0;
`else
  assign issue_lock = win_q ? lock1 : lock0;
`endif

  always_ff @(posedge CLK) begin
    if (!NCLR) begin
      state_q      <= ST_IDLE;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      lock_valid_q <= 1'b0;
      lock_id_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      rdata_q      <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      if (take) begin
        win_q      <= win_d;
        we_q       <= win_d ? we1 : we0;
        ram_addr_q <= win_d ? addr1 : addr0;
        ram_din_q  <= win_d ? wdata1 : wdata0;
      end
      if (state_q == ST_ISSUE) begin
        last_grant_q <= win_q;
        lock_valid_q <= issue_lock;
        lock_id_q    <= win_q;
      end
      if (state_q == ST_RESP) begin
        rdata_q   <= ram_dout;
        rvalid0_q <= ~win_q;
        rvalid1_q <= win_q;
      end
    end
  end

  // Strobes are gated by NCLR so a reset landing on the ISSUE edge abandons the access.
  assign gnt0      = NCLR && (state_q == ST_ISSUE) && !win_q;
  assign gnt1      = NCLR && (state_q == ST_ISSUE) && win_q;
  assign ram_we    = NCLR && (state_q == ST_ISSUE) && we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign rdata     = rdata_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign busy      = (state_q != ST_IDLE);
  assign fsm_state = state_q;

endmodule
